// File: rtl/counter_pkg.sv
// Shared constants for the delayed-pulse timer: default widths and FSM state codes.
package counter_pkg;

   localparam int W_DEF  = 32;
   localparam int PW_DEF = 16;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] COUNT = 1'b1;

endpackage

// File: rtl/pulse_after_n_clks.sv
// Emits a one-cycle pulse D cycles after an accepted start, one-shot or periodic,
// with cancel, retrigger, a saturating pulse counter and an error strobe for D==0.
module pulse_after_n_clks
   import counter_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  delay,
   input  logic          periodic,
   input  logic          cancel,
   output logic          pulse,
   output logic          busy,
   output logic [W-1:0]  elapsed,
   output logic [PW-1:0] pulse_cnt,
   output logic          err
);

   localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};

   logic [0:0]    state_q,   state_d;
   logic [W-1:0]  dly_q,     dly_d;
   logic          mode_q,    mode_d;
   logic [W-1:0]  elapsed_q, elapsed_d;
   logic [PW-1:0] cnt_q,     cnt_d;
   logic          pulse_q,   pulse_d;
   logic          err_q,     err_d;
   logic          expire;
   logic          accept;

   // The pulse cycle is the one in which elapsed equals the latched delay.
   assign expire = (state_q == COUNT) && (elapsed_q == dly_q);
   assign accept = start && (delay != '0);

   // NOTE: every next-state variable is defaulted first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      mode_d    = mode_q;
      elapsed_d = elapsed_q;
      cnt_d     = cnt_q;
      err_d     = start && (delay == '0);

      if (cancel) begin
         state_d   = IDLE;
         elapsed_d = '0;
      end else if (accept) begin
         state_d   = COUNT;
         dly_d     = delay;
         mode_d    = periodic;
         elapsed_d = W'(1);
         cnt_d     = '0;
      end else if (expire) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PW'(1);
         if (mode_q) begin
            elapsed_d = W'(1);
         end else begin
            state_d   = IDLE;
            elapsed_d = '0;
         end
      end else if (state_q == COUNT) begin
         elapsed_d = elapsed_q + W'(1);
      end

      // Decided from next-state values so the strobe is a flop aligned with elapsed==D.
      pulse_d = (state_d == COUNT) && (elapsed_d == dly_d);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         dly_q     <= '0;
         mode_q    <= 1'b0;
         elapsed_q <= '0;
         cnt_q     <= '0;
         pulse_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         mode_q    <= mode_d;
         elapsed_q <= elapsed_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         err_q     <= err_d;
      end
   end

   assign pulse     = pulse_q;
   assign busy      = (state_q == COUNT);
   assign elapsed   = elapsed_q;
   assign pulse_cnt = cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pulse_after_n_clks.sv
// Bench for pulse_after_n_clks: directed scenarios plus random traffic, checked against
// a model that tracks absolute edge numbers of the last start/reload.
module tb_pulse_after_n_clks;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] delay;
   logic        periodic;
   logic        cancel;

   logic        pulse, busy, err;
   logic [31:0] elapsed;
   logic [15:0] pulse_cnt;

   logic        pulse2, busy2, err2;
   logic [7:0]  elapsed2;
   logic [1:0]  pulse_cnt2;

   pulse_after_n_clks #(.W(32), .PW(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .delay(delay), .periodic(periodic),
      .cancel(cancel), .pulse(pulse), .busy(busy), .elapsed(elapsed),
      .pulse_cnt(pulse_cnt), .err(err)
   );

   pulse_after_n_clks #(.W(8), .PW(2)) u_sat (
      .clk(clk), .rst(rst), .start(start), .delay(delay[7:0]), .periodic(periodic),
      .cancel(cancel), .pulse(pulse2), .busy(busy2), .elapsed(elapsed2),
      .pulse_cnt(pulse_cnt2), .err(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   string phase    = "reset";

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s:%s got %0d expected %0d at %0t", phase, tag, got, exp, $time);
      end
   endtask

   // Reference model: absolute edge count, edge of last start/reload, latched D and mode.
   longint edge_n;
   longint m_ref;
   longint m_d;
   bit     m_active, m_per, m_err;
   int     m_cnt, m_cnt2;

   function automatic longint exp_elapsed();
      return m_active ? (edge_n - m_ref + 1) : 0;
   endfunction

   function automatic bit exp_pulse();
      return m_active && (exp_elapsed() == m_d);
   endfunction

   task automatic model_reset();
      m_active = 0; m_per = 0; m_err = 0; m_d = 0; m_ref = 0;
      m_cnt = 0; m_cnt2 = 0;
   endtask

   task automatic model_edge(input bit s, input longint dl, input bit p, input bit c);
      bit fire;
      fire = exp_pulse();
      edge_n++;
      m_err = s && (dl == 0);
      if (c) begin
         m_active = 0;
      end else if (s && dl != 0) begin
         m_active = 1; m_d = dl; m_per = p; m_ref = edge_n;
         m_cnt = 0; m_cnt2 = 0;
      end else if (fire) begin
         m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
         m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
         if (m_per) m_ref = edge_n;
         else       m_active = 0;
      end
   endtask

   task automatic compare_all();
      check("pulse",      pulse,      exp_pulse());
      check("busy",       busy,       m_active);
      check("elapsed",    elapsed,    exp_elapsed());
      check("pulse_cnt",  pulse_cnt,  m_cnt);
      check("err",        err,        m_err);
      check("sat_pulse",  pulse2,     exp_pulse());
      check("sat_cnt",    pulse_cnt2, m_cnt2);
   endtask

   // One clock: compare outputs at the falling edge, drive inputs, then advance the model.
   task automatic cyc(input bit s, input int dl, input bit p, input bit c);
      @(negedge clk);
      compare_all();
      start = s; delay = 32'(dl); periodic = p; cancel = c;
      @(posedge clk);
      model_edge(s, dl, p, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic check_all_zero();
      check("rst_pulse",   pulse,     0);
      check("rst_busy",    busy,      0);
      check("rst_elapsed", elapsed,   0);
      check("rst_cnt",     pulse_cnt, 0);
      check("rst_err",     err,       0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; delay = '0; periodic = 1'b0; cancel = 1'b0;
      edge_n = 0;
      model_reset();
      #3;
      check_all_zero();
      @(posedge clk);
      #2 rst = 1'b1;

      phase = "oneshot";
      cyc(1, 5, 0, 0);
      idle(8);

      phase = "periodic";
      cyc(1, 3, 1, 0);
      idle(6);
      cyc(0, 0, 0, 1);
      idle(4);

      phase = "retrigger";
      cyc(1, 10, 0, 0);
      idle(3);
      cyc(1, 2, 0, 0);
      idle(10);

      phase = "delay1";
      cyc(1, 1, 0, 0);
      idle(3);

      phase = "delay0";
      cyc(1, 0, 1, 0);
      idle(3);

      phase = "cancel_expiry";
      cyc(1, 3, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      idle(4);

      phase = "restart_on_pulse";
      cyc(1, 2, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 3, 0, 0);
      idle(5);

      phase = "async_reset";
      cyc(1, 4, 0, 0);
      cyc(0, 0, 0, 0);
      start = 1'b0; delay = '0; periodic = 1'b0; cancel = 1'b0;
      #3 rst = 1'b0;
      #1 check_all_zero();
      model_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      idle(6);

      phase = "post_reset_start";
      cyc(1, 2, 0, 0);
      idle(4);

      phase = "saturation";
      cyc(1, 1, 1, 0);
      idle(7);
      cyc(0, 0, 0, 1);
      idle(2);

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         bit s, p, c;
         int dl;
         s  = ($urandom_range(0, 6) == 0);
         dl = $urandom_range(0, 9);
         p  = $urandom_range(0, 1) == 1;
         c  = ($urandom_range(0, 15) == 0);
         cyc(s, dl, p, c);
      end
      idle(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
